// File: rtl/cpu_dbg_pkg.sv
// Shared debug-dump types and defaults.
// State encoding plus register-file geometry.
package cpu_dbg_pkg;
  typedef enum logic [1:0] {
    IDLE,
    HALT,
    SEND,
    DONE
  } state_t;

  localparam int DEFAULT_END_COUNT = 25;
  localparam int REG_ADDR_W        = 5;
  localparam int DATA_W            = 32;
endpackage

// File: rtl/reg_dump_trigger.sv
// Dump trigger: saturating post-reset counter OR start pulse.
// Ports: clk_i, rst_i (async low), arm_i, start_i -> trig_o.
module dump_trigger #(
  parameter int END_COUNT = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arm_i,
  input  logic start_i,
  output logic trig_o
);
  import cpu_dbg_pkg::*;

  localparam int CW =
    (END_COUNT > 0) ? $clog2(END_COUNT + 1) : 1;
  localparam logic [CW-1:0] SAT = CW'(END_COUNT);
  localparam logic [CW-1:0] LAST =
    CW'((END_COUNT > 0) ? END_COUNT - 1 : 0);
  localparam bit AUTO = (END_COUNT != 0);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (arm_i && count_q != SAT) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q==LAST means this edge is the END_COUNT-th one
  assign trig_o = arm_i &
    (start_i | (AUTO & (count_q == LAST)));
endmodule

// File: rtl/reg_dump_streamer.sv
// Halts the CPU and streams {index, value} beats of the RF.
// Ports: clk_i, rst_i, start_i, halt_o, rf_*, dump_*, done_o.
module reg_dump_streamer #(
  parameter int END_COUNT = cpu_dbg_pkg::DEFAULT_END_COUNT,
  parameter int NUM_REGS  = 13,
  parameter int DATA_W    = cpu_dbg_pkg::DATA_W,
  parameter int ADDR_W    = cpu_dbg_pkg::REG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              halt_o,
  output logic [ADDR_W-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o
);
  import cpu_dbg_pkg::*;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              idle;
  logic              trig;
  logic              is_last;

  assign idle    = (state_q == IDLE);
  assign is_last = (idx_q == LAST);

  dump_trigger #(
    .END_COUNT(END_COUNT)
  ) u_trig (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .arm_i  (idle),
    .start_i(start_i),
    .trig_o (trig)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    data_d       = data_q;
    halt_o       = 1'b0;
    rf_raddr_o   = '0;
    dump_valid_o = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) state_d = HALT;
      end
      HALT: begin
        halt_o  = 1'b1;
        state_d = SEND;
        idx_d   = '0;
        data_d  = rf_rdata_i;
      end
      SEND: begin
        halt_o       = 1'b1;
        dump_valid_o = 1'b1;
        // prefetch next register so beats go 1/cycle
        rf_raddr_o   = is_last ? '0 : idx_q + 1'b1;
        if (dump_ready_i) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = rf_rdata_i;
          end
        end
      end
      DONE: begin
        halt_o = 1'b1;
        done_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_idx_o  = idx_q;
  assign dump_data_o = data_q;
endmodule
